// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity modes
// and the default bit divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned PARITY_NONE = 32'd0;
  localparam int unsigned PARITY_EVEN = 32'd1;
  localparam int unsigned PARITY_ODD  = 32'd2;

  // 50 MHz system clock at 115200 baud
  localparam int unsigned DEFAULT_BAUD_DIV = 32'd434;

  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    logic p;
    p = ^data;
    if (mode == PARITY_ODD) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty are judged on the
// registered occupancy so a push while full is always dropped.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0]   DEPTH_C   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE_C = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  // Accept/release decisions, pointer and occupancy update
  always_comb begin
    do_push_s = push && !full_q;
    do_pop_s  = pop && !empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNT_ONE_C;
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - CNT_ONE_C;
    end else begin
      count_d = count_q;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == {(AW+1){1'b0}});
  end

  // Pointer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8-bit UART transmitter: bytes queue in a FIFO and are serialised
// LSB-first as start, data, optional parity and stop bits on txd.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int unsigned PARITY   = PARITY_NONE,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             clr_ovf,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] fifo_count,
  output logic             ovf,
  output logic             tx_busy,
  output logic             txd
);

  localparam logic [15:0] BAUD_LAST_C = 16'(BAUD_DIV - 32'd1);
  localparam logic        HAS_PAR_C   = (PARITY != PARITY_NONE);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        tick_s;
  logic        pop_s;
  logic [7:0]  head_s;
  logic        fifo_full_s, fifo_empty_s;

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .pop     (pop_s),
    .wr_data (wr_data),
    .rd_data (head_s),
    .count   (fifo_count),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign tick_s = (baud_cnt_q == BAUD_LAST_C);

  // Frame sequencing: bit timing, byte load from the FIFO and bit stepping
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop_s     = 1'b0;
    if (tick_s) begin
      baud_cnt_d = 16'd0;
    end else begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = 16'd0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          par_d   = parity_bit(head_s, PARITY);
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = HAS_PAR_C ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        // A queued byte starts the next frame with no idle gap
        if (tick_s) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            par_d   = parity_bit(head_s, PARITY);
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = 16'd0;
      end
    endcase
  end

  // Line level for the current bit, plus status outputs
  always_comb begin
    case (state_q)
      ST_IDLE:   txd_d = 1'b1;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
      ST_PARITY: txd_d = par_q;
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    if (wr_en && fifo_full_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmit state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign full    = fifo_full_s;
  assign empty   = fifo_empty_s;
  assign ovf     = ovf_q;
  assign tx_busy = busy_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT line monitors
// decode txd at mid-bit and compare in order.
module tb_uart_transmitter;

  localparam int BD = 4;

  logic clk, rst_n, wr_en, wr_en_p, clr_ovf;
  logic [7:0] wr_data;
  logic full0, empty0, ovf0, busy0, txd0;
  logic full1, empty1, ovf1, busy1, txd1;
  logic full2, empty2, ovf2, busy2, txd2;
  logic [4:0] cnt0, cnt1, cnt2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [8:0] sb0[$];
  logic [8:0] sb1[$];
  logic [8:0] sb2[$];
  int starts0[$];

  uart_transmitter #(.BAUD_DIV(BD), .PARITY(0), .FIFO_AW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full0), .empty(empty0), .fifo_count(cnt0), .ovf(ovf0), .tx_busy(busy0), .txd(txd0));
  uart_transmitter #(.BAUD_DIV(BD), .PARITY(1), .FIFO_AW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_p), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full1), .empty(empty1), .fifo_count(cnt1), .ovf(ovf1), .tx_busy(busy1), .txd(txd1));
  uart_transmitter #(.BAUD_DIV(BD), .PARITY(2), .FIFO_AW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_p), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full2), .empty(empty2), .fifo_count(cnt2), .ovf(ovf2), .tx_busy(busy2), .txd(txd2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line(input int idx);
    case (idx)
      0:       return txd0;
      1:       return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic int sb_size(input int idx);
    case (idx)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic logic [8:0] sb_pop(input int idx);
    case (idx)
      0:       return sb0.pop_front();
      1:       return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  task automatic wait_bits(input int n, inout logic ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  // Called on the first low sample of a start bit; samples each later bit mid-way
  task automatic decode_frame(input int idx, input logic with_par, output logic [8:0] got,
                              output logic st, output logic sp, output logic ab);
    ab  = 1'b0;
    got = 9'd0;
    wait_bits(BD / 2, ab);
    st = line(idx);
    for (int b = 0; b < 8; b++) begin
      wait_bits(BD, ab);
      got[b] = line(idx);
    end
    if (with_par) begin
      wait_bits(BD, ab);
      got[8] = line(idx);
    end
    wait_bits(BD, ab);
    sp = line(idx);
  endtask

  task automatic monitor_loop(input int idx);
    logic [8:0] got, exp;
    logic st, sp, ab;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && line(idx) === 1'b0) begin
        if (idx == 0) starts0.push_back(cyc);
        decode_frame(idx, idx != 0, got, st, sp, ab);
        if (!ab) begin
          if (sb_size(idx) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame%0d_unexpected: got %03h expected no frame", idx, got);
          end else begin
            exp = sb_pop(idx);
            check($sformatf("frame%0d_data_par", idx), 32'(got), 32'(exp));
            check($sformatf("frame%0d_start", idx), 32'(st), 32'd0);
            check($sformatf("frame%0d_stop", idx), 32'(sp), 32'd1);
          end
        end
      end
    end
  endtask

  initial monitor_loop(0);
  initial monitor_loop(1);
  initial monitor_loop(2);

  task automatic wait_idle(input string tag);
    int g = 0;
    while (!(busy0 === 1'b0 && empty0 === 1'b1 && busy1 === 1'b0 && busy2 === 1'b0 &&
             sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    n_vec++;
    if (g >= 3000) begin
      n_err++;
      $display("FAIL %s_idle_timeout: got still busy after %0d cycles expected idle", tag, g);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int nb, peak, c0, hi;
    rst_n = 1'b0; wr_en = 1'b0; wr_en_p = 1'b0; clr_ovf = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", txd0, 1); check("rst_busy", busy0, 0); check("rst_full", full0, 0);
    check("rst_empty", empty0, 1); check("rst_count", cnt0, 0); check("rst_ovf", ovf0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, latency and frame length
    wr_en = 1'b1; wr_data = 8'hA5; sb0.push_back(9'h0A5);
    @(negedge clk); wr_en = 1'b0;
    check("t1_cnt_e0", cnt0, 1); check("t1_txd_e0", txd0, 1); check("t1_busy_e0", busy0, 0);
    @(negedge clk);
    check("t1_txd_e1", txd0, 1); check("t1_busy_e1", busy0, 1); check("t1_cnt_e1", cnt0, 0);
    nb = 1;
    @(negedge clk);
    check("t1_txd_e2", txd0, 0);
    while (busy0 === 1'b1 && nb < 1000) begin nb++; @(negedge clk); end
    check("t1_busy_cycles", nb, 40);
    wait_idle("t1");

    // Parity variants: 0x07 has odd popcount
    wr_en_p = 1'b1; wr_data = 8'h07;
    sb1.push_back(9'h107); sb2.push_back(9'h007);
    @(negedge clk); wr_en_p = 1'b0;
    @(negedge clk);
    nb = 0;
    while (busy1 === 1'b1 && nb < 1000) begin nb++; @(negedge clk); end
    check("t2_busy_cycles", nb, 44);
    check("t2_odd_busy_done", busy2, 0);
    wait_idle("t2");

    // Three back-to-back bytes
    starts0.delete();
    peak = 0;
    wr_en = 1'b1; wr_data = 8'h11; sb0.push_back(9'h011);
    @(negedge clk); wr_data = 8'h22; sb0.push_back(9'h022);
    if (int'(cnt0) > peak) peak = int'(cnt0);
    @(negedge clk); wr_data = 8'h33; sb0.push_back(9'h033);
    if (int'(cnt0) > peak) peak = int'(cnt0);
    @(negedge clk); wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (int'(cnt0) > peak) peak = int'(cnt0);
      @(negedge clk);
    end
    check("t3_count_peak", peak, 2);
    wait_idle("t3");
    check("t3_frames", starts0.size(), 3);
    if (starts0.size() == 3) begin
      check("t3_gap_1_2", starts0[1] - starts0[0], 40);
      check("t3_gap_2_3", starts0[2] - starts0[1], 40);
    end

    // Fill to full, overflow, clear, then push coinciding with a pop
    wr_en = 1'b1; wr_data = 8'h40; sb0.push_back(9'h040);
    @(negedge clk); c0 = cyc;
    for (int i = 1; i < 17; i++) begin
      wr_data = 8'(8'h40 + i); sb0.push_back({1'b0, 8'(8'h40 + i)});
      @(negedge clk);
    end
    check("t4_full", full0, 1); check("t4_count16", cnt0, 16); check("t4_ovf_pre", ovf0, 0);
    wr_data = 8'hEE;
    @(negedge clk); wr_en = 1'b0;
    check("t4_ovf_set", ovf0, 1); check("t4_count_hold", cnt0, 16);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    check("t4_ovf_clr", ovf0, 0);
    while (cyc < c0 + 40) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hDD;
    @(negedge clk);
    check("t6_count15", cnt0, 15); check("t6_ovf", ovf0, 1); check("t6_not_full", full0, 0);
    wr_data = 8'hCC; sb0.push_back(9'h0CC);
    @(negedge clk); wr_en = 1'b0;
    check("t6_count16", cnt0, 16); check("t6_full", full0, 1);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    wait_idle("t4");

    // Reset during data bit 3 of 0xFF with two bytes queued
    wr_en = 1'b1; wr_data = 8'hFF; sb0.push_back(9'h0FF);
    @(negedge clk); c0 = cyc; wr_data = 8'h12; sb0.push_back(9'h012);
    @(negedge clk); wr_data = 8'h34; sb0.push_back(9'h034);
    @(negedge clk); wr_en = 1'b0;
    while (cyc < c0 + 19) @(negedge clk);
    check("t5_busy_pre", busy0, 1); check("t5_count_pre", cnt0, 2);
    rst_n = 1'b0;
    sb0.delete();
    #1;
    check("t5_txd_async", txd0, 1); check("t5_busy_async", busy0, 0);
    check("t5_empty_async", empty0, 1); check("t5_count_async", cnt0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd0 === 1'b1) hi++;
    end
    check("t5_txd_high_100", hi, 100);
    check("t5_empty_after", empty0, 1);

    check("end_sb0_empty", sb0.size(), 0);
    check("end_sb1_empty", sb1.size(), 0);
    check("end_sb2_empty", sb2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
